// File: rtl/n_term_pipe.sv
// North-terminating tile: turns incoming north wires back south under a 2-bit
// per-class mode held in a frame-loaded register, and forwards the config chain.
module n_term_pipe #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int PIPE_STAGES     = 1,
    parameter int CFG_FRAME       = 0,
    parameter int N1W             = 4,
    parameter int N2W             = 8,
    parameter int N4W             = 16
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [N1W-1:0]             N1END,
    input  logic [N2W-1:0]             N2MID,
    input  logic [N2W-1:0]             N2END,
    input  logic [N4W-1:0]             N4END,
    output logic [N1W-1:0]             S1BEG,
    output logic [N2W-1:0]             S2BEG,
    output logic [N2W-1:0]             S2BEGb,
    output logic [N4W-1:0]             S4BEG,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    output logic                       CfgValid
);

    logic [FrameBitsPerRow-1:0] stage_data_s;
    logic [MaxFramesPerCol-1:0] stage_strobe_s;

    // Data and strobe always travel together so the mode load sees a matched pair.
    generate
        if (PIPE_STAGES == 0) begin : g_comb
            assign stage_data_s   = FrameData;
            assign stage_strobe_s = FrameStrobe;
        end else begin : g_pipe
            logic [FrameBitsPerRow-1:0] data_d   [PIPE_STAGES];
            logic [FrameBitsPerRow-1:0] data_q   [PIPE_STAGES];
            logic [MaxFramesPerCol-1:0] strobe_d [PIPE_STAGES];
            logic [MaxFramesPerCol-1:0] strobe_q [PIPE_STAGES];

            // Shift chain next-state
            always_comb begin
                data_d[0]   = FrameData;
                strobe_d[0] = FrameStrobe;
                for (int i = 1; i < PIPE_STAGES; i++) begin
                    data_d[i]   = data_q[i-1];
                    strobe_d[i] = strobe_q[i-1];
                end
            end

            // Config chain registers
            always_ff @(posedge UserCLK or posedge Reset) begin
                if (Reset) begin
                    for (int i = 0; i < PIPE_STAGES; i++) begin
                        data_q[i]   <= '0;
                        strobe_q[i] <= '0;
                    end
                end else begin
                    data_q   <= data_d;
                    strobe_q <= strobe_d;
                end
            end

            assign stage_data_s   = data_q[PIPE_STAGES-1];
            assign stage_strobe_s = strobe_q[PIPE_STAGES-1];
        end
    endgenerate

    assign FrameData_O   = stage_data_s;
    assign FrameStrobe_O = stage_strobe_s;
    assign UserCLKo      = UserCLK;

    logic [7:0]     mode_d, mode_q;
    logic           cfg_valid_d, cfg_valid_q;
    logic [N1W-1:0] n1_d, n1_q;
    logic [N2W-1:0] n2m_d, n2m_q;
    logic [N2W-1:0] n2e_d, n2e_q;
    logic [N4W-1:0] n4_d, n4_q;

    // Mode load and loopback capture next-state
    always_comb begin
        mode_d      = mode_q;
        cfg_valid_d = cfg_valid_q;
        if (stage_strobe_s[CFG_FRAME]) begin
            mode_d      = stage_data_s[7:0];
            cfg_valid_d = 1'b1;
        end else begin
            mode_d      = mode_q;
            cfg_valid_d = cfg_valid_q;
        end
        n1_d  = N1END;
        n2m_d = N2MID;
        n2e_d = N2END;
        n4_d  = N4END;
    end

    // Mode register and always-running loopback registers
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            mode_q      <= 8'h00;
            cfg_valid_q <= 1'b0;
            n1_q        <= '0;
            n2m_q       <= '0;
            n2e_q       <= '0;
            n4_q        <= '0;
        end else begin
            mode_q      <= mode_d;
            cfg_valid_q <= cfg_valid_d;
            n1_q        <= n1_d;
            n2m_q       <= n2m_d;
            n2e_q       <= n2e_d;
            n4_q        <= n4_d;
        end
    end

    assign CfgValid = cfg_valid_q;

    // Class-1 turnaround
    always_comb begin
        case (mode_q[1:0])
            2'b00:   S1BEG = N1END;
            2'b01:   S1BEG = n1_q;
            2'b10:   S1BEG = '0;
            2'b11:   S1BEG = ~N1END;
            default: S1BEG = N1END;
        endcase
    end

    // N2MID turnaround
    always_comb begin
        case (mode_q[3:2])
            2'b00:   S2BEG = N2MID;
            2'b01:   S2BEG = n2m_q;
            2'b10:   S2BEG = '0;
            2'b11:   S2BEG = ~N2MID;
            default: S2BEG = N2MID;
        endcase
    end

    // N2END turnaround
    always_comb begin
        case (mode_q[5:4])
            2'b00:   S2BEGb = N2END;
            2'b01:   S2BEGb = n2e_q;
            2'b10:   S2BEGb = '0;
            2'b11:   S2BEGb = ~N2END;
            default: S2BEGb = N2END;
        endcase
    end

    // Class-4 turnaround
    always_comb begin
        case (mode_q[7:6])
            2'b00:   S4BEG = N4END;
            2'b01:   S4BEG = n4_q;
            2'b10:   S4BEG = '0;
            2'b11:   S4BEG = ~N4END;
            default: S4BEG = N4END;
        endcase
    end

endmodule

// File: doc/n_term_pipe.md
N_TERM_PIPE -- requirements
Module: n_term_pipe

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, frame strobe width.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, frame data width (minimum 8).
REQ-003 SHALL have parameter PIPE_STAGES, default 1, number of register stages on the config path (range 0..4).
REQ-004 SHALL have parameter CFG_FRAME, default 0, index of the strobe bit that loads this tile's mode register.
REQ-005 SHALL have parameters N1W=4, N2W=8, N4W=16, the wire counts per wire class.
REQ-006 SHALL have port UserCLK, input, 1, the single clock for all state.
REQ-007 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port N1END/N2MID/N2END/N4END, input, N1W/N2W/N2W/N4W, incoming wires.
REQ-009 SHALL have port S1BEG/S2BEG/S2BEGb/S4BEG, output, N1W/N2W/N2W/N4W, turned-around wires.
REQ-010 SHALL have port FrameData/FrameStrobe, input, FrameBitsPerRow/MaxFramesPerCol, config chain in.
REQ-011 SHALL have port FrameData_O/FrameStrobe_O, output, same widths, config chain out.
REQ-012 SHALL have port UserCLKo, output, 1, buffered UserCLK.
REQ-013 SHALL have port CfgValid, output, 1, high once the mode register has been loaded.

Function
REQ-014 SHALL delay FrameData/FrameStrobe through exactly PIPE_STAGES UserCLK registers to FrameData_O/FrameStrobe_O; with PIPE_STAGES=0 the path SHALL be combinational.
REQ-015 SHALL load mode register MODE[7:0] from the stage-PIPE_STAGES FrameData[7:0] on any rising UserCLK edge where the same stage's FrameStrobe[CFG_FRAME]=1; data and strobe SHALL always be sampled from the same stage.
REQ-016 SHALL treat MODE as four 2-bit fields: [1:0] class 1 (N1END->S1BEG), [3:2] N2MID->S2BEG, [5:4] N2END->S2BEGb, [7:6] N4END->S4BEG.
REQ-017 SHALL, per field: 00 = direct combinational loopback; 01 = registered loopback, 1-cycle latency; 10 = drive all 0; 11 = bitwise inverted direct loopback.
REQ-018 SHALL keep per-class loopback registers clocked every cycle regardless of mode, so switching to 01 outputs the previous cycle's input immediately.
REQ-019 SHALL apply a new MODE from the cycle after the load edge; a strobe held high for N cycles SHALL reload MODE on each of the N edges (last value wins).
REQ-020 SHALL set CfgValid=1 on the first MODE load and hold it until reset.
REQ-021 SHALL drive UserCLKo = UserCLK with no logic other than a clock buffer.
REQ-022 SHALL ignore FrameData bits above [7] for MODE purposes but forward them unchanged.
REQ-023 SHALL ignore FrameStrobe bits other than CFG_FRAME for MODE purposes.

Reset
REQ-024 SHALL, while Reset=1, asynchronously clear all pipeline stages (FrameData_O=0, FrameStrobe_O=0 when PIPE_STAGES>0), MODE=8'h00, loopback registers=0, CfgValid=0.
REQ-025 SHALL make a reset asserted mid-load discard the load; after deassertion the tile SHALL be in direct-loopback mode with CfgValid=0.
REQ-026 SHALL resume normal operation on the first UserCLK edge after Reset deassertion.

Verification
REQ-027 SHALL cover: reset, no load -> S1BEG==N1END, S4BEG==N4END combinationally; CfgValid=0.
REQ-028 SHALL cover: PIPE_STAGES=2, FrameData=32'hA5A5_00E4 with strobe[0] one cycle -> FrameData_O shows the value exactly 2 edges later; MODE=8'hE4 from the next cycle (S1 direct, S2 registered, S2b zero, S4 inverted); CfgValid=1.
REQ-029 SHALL cover: MODE=8'h55, N2MID steps 8'h01,8'h02 -> S2BEG lags by exactly one cycle; S1BEG lags by one cycle.
REQ-030 SHALL cover: strobe[1] only with CFG_FRAME=0 -> MODE unchanged, FrameStrobe_O still forwards the bit.
REQ-031 SHALL cover: Reset pulsed between data entering stage 1 and reaching the load stage -> no MODE load, FrameData_O=0, CfgValid=0.
REQ-032 SHALL cover: PIPE_STAGES=0, strobe held 3 cycles with data 8'h00,8'hFF,8'hAA -> final MODE=8'hAA; outputs follow each value one cycle after its load edge.
